// File: rtl/ring_osc_monitor_if.sv
// ring_osc_monitor_if -- register-side handshake between the test sequencer
// and the ring-oscillator monitor.
//   start    : sequencer requests a measurement (sampled by the monitor in IDLE)
//   win_len  : window length in clocks, captured with start (0 acts as 1)
//   busy     : measurement in progress (start acceptance through DONE)
//   done     : one-cycle pulse, results valid
//   count    : saturating rising-edge count of the last window
//   stuck    : last window counted no edges
//   overflow : counter saturated during the last window
interface ring_osc_monitor_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             stuck;
  logic             overflow;

  modport master (output start, win_len, input busy, done, count, stuck, overflow);
  modport slave  (input start, win_len, output busy, done, count, stuck, overflow);
endinterface

// File: rtl/ring_osc_monitor.sv
// ring_osc_monitor -- gates a ring oscillator, waits a settle period, then
// counts rising edges of a synchronised ring tap over a programmable window.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   ring_tap : asynchronous tap from the ring
//   ring_en  : registered ring enable (drives the ring's NAND stage)
//   bus      : start/win_len in, busy/done/count/stuck/overflow out
module ring_osc_monitor #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ring_tap,
  output logic                ring_en,
  ring_osc_monitor_if.slave   bus
);

  // One down-counter times both the settle period and the window.
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stuck_q, stuck_d;
  logic                   ovf_q, ovf_d;
  logic                   ring_en_q, ring_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    stuck_d   = stuck_q;
    ovf_d     = ovf_q;
    ring_en_d = ring_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Synchroniser and edge-history run continuously; only MEASURE counts.
    sync_d    = {sync_q[SYNC_STAGES-2:0], ring_tap};
    prev_d    = sync_q[SYNC_STAGES-1];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SETTLE;
          win_d     = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
          tmr_d     = TMR_W'(SETTLE_CYC - 1);
          cnt_d     = '0;
          stuck_d   = 1'b0;
          ovf_d     = 1'b0;
          ring_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = MEASURE;
          tmr_d   = TMR_W'(win_q) - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          if (&cnt_q) ovf_d = 1'b1;       // saturate, never wrap
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) begin
          // The edge on this final window clock is included in the result.
          state_d   = DONE;
          ring_en_d = 1'b0;
          done_d    = 1'b1;
          stuck_d   = (cnt_d == '0);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      win_q     <= '0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      stuck_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      win_q     <= win_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      stuck_q   <= stuck_d;
      ovf_q     <= ovf_d;
      ring_en_q <= ring_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ring_en      = ring_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = cnt_q;
  assign bus.stuck    = stuck_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/ring_osc_monitor.md
# ring_osc_monitor

Synchronous controller and frequency monitor for the inverter-plus-buffer ring-oscillator benchmarks. It gates the ring's enable and, after a fixed settle period, counts rising edges of one synchronised ring tap over a programmable window of system clocks. It then reports the edge count, a stuck-ring flag and an overflow flag through a start/done handshake. It sits between the test sequencer (register interface) and one gated ring instance; the ring's first inverter becomes a NAND with `ring_en`.

## Interface

Parameters:
- `CNT_W`, 16: width of the edge counter and `count` result.
- `WIN_W`, 16: width of the `win_len` window-length input.
- `SYNC_STAGES`, 2: flip-flop stages synchronising `ring_tap` (minimum 2).
- `SETTLE_CYC`, 4: clocks between enabling the ring and opening the window (minimum 1).

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a measurement; sampled only in IDLE.
- `win_len`, in, WIN_W: window length in clocks; captured with `start`; 0 is treated as 1.
- `ring_tap`, in, 1: asynchronous tap from the ring; any ring node is acceptable.
- `ring_en`, out, 1: enables the ring oscillation; registered.
- `busy`, out, 1: high from `start` acceptance through the DONE state.
- `done`, out, 1: one-cycle pulse when the results are valid.
- `count`, out, CNT_W: rising edges counted in the window; saturating; held until the next accepted `start`.
- `stuck`, out, 1: the window closed with `count` equal to 0; held with `count`.
- `overflow`, out, 1: the counter saturated during the window; held with `count`.

## Operation

- **Reset values:** all outputs are 0, the state is IDLE, the synchroniser is cleared and the previous-tap register is 0.
- **FSM states:** IDLE, SETTLE, MEASURE, DONE.
  - **IDLE → SETTLE** on `start`=1.
    - Capture `win_len` (0 becomes 1).
    - Clear the counter, `stuck` and `overflow`.
    - Set `ring_en`=1 and `busy`=1.
  - **SETTLE → MEASURE** after exactly SETTLE_CYC clocks in SETTLE. During SETTLE the synchroniser and the previous-tap register run, but no edges are counted.
  - **MEASURE → DONE** after exactly the captured `win_len` clocks in MEASURE. In each MEASURE clock, the counter increments when the synchronised tap is 1 and the previous synchronised tap is 0.
  - **DONE → IDLE** after exactly 1 clock.
    - On entering DONE: `ring_en`=0, `done`=1, and `stuck` is set if the final count is 0.
    - On leaving DONE: `busy`=0 and `done`=0.
- **Arithmetic:** the counter saturates at 2^CNT_W−1. An increment attempted at saturation sets `overflow` sticky. The counter never wraps.
- **`start` outside IDLE** (SETTLE, MEASURE or DONE) is ignored; it is neither queued nor allowed to restart the window.
- **`start` held high continuously:** a new measurement begins on the first IDLE cycle after DONE, so back-to-back runs are separated by one IDLE clock.
- **Mid-operation reset:** at the next edge the block returns to the reset state. `ring_en` drops, the results clear, and no `done` pulse is produced.
- **`win_len` changes** after capture have no effect on the run in progress.

## Timing

- `start` sampled high at edge E0 makes `ring_en`=1 and `busy`=1 visible after E0.
- The window covers the clocks from edge E0+SETTLE_CYC+1 through edge E0+SETTLE_CYC+`win_len`.
- `done`=1 and the results are valid after edge E0+SETTLE_CYC+`win_len`. `ring_en` falls at that same edge.
- Measurement latency from `start` to `done` is SETTLE_CYC+`win_len` clocks.
- Synchroniser latency is SYNC_STAGES clocks. Edges that occur in the final SYNC_STAGES clocks before `ring_en` falls may go uncounted; this is accepted.
- Tap frequency must be below clk/2 for an exact count. Faster taps alias and are not flagged.

## Test plan

- **Nominal:** `ring_tap` period 10 clk (50% duty), `win_len`=100, SETTLE_CYC=4, start at edge 0 → `done` after edge 104, `count`=10, `stuck`=0, `overflow`=0, `ring_en` high for edges 1..104.
- **Stuck ring:** `ring_tap` held 0, `win_len`=50 → `done` after edge 54, `count`=0, `stuck`=1, `overflow`=0.
- **Saturation:** CNT_W=4, tap period 2 clk, `win_len`=64 → `count`=15, `overflow`=1, `stuck`=0.
- **Protocol:**
  - `win_len`=0 → a 1-clock window, with `done` after edge SETTLE_CYC+1.
  - A `start` pulse during MEASURE is ignored: exactly one `done` pulse, and results are unchanged relative to a run without the pulse.
  - `start` held high gives back-to-back runs with one IDLE clock between `done` and the next `ring_en` rise.
- **Reset mid-measure:** assert `rst` for 1 clk at edge 30 of a 100-clk window → after that edge all outputs are 0 and no `done` ever follows; a new `start` then completes normally with the correct count.
